// File: rtl/hps_cmd_decoder.sv
// hps_cmd_decoder: splits io_enable framed HPS SPI words into a command
// word plus data words and updates core-side registers (joysticks,
// buttons, status). io_dout carries the word shifted back to the HPS on
// the following transfer.
// Optional feature macro: HPS_CMD_STATUS_READBACK_EN enables the
// STATUS_GET (16'h0029) readback mux; without it 16'h0029 is unknown.
//
// Handshake: io_strobe is a one-cycle qualifier for io_din. A word is
// accepted on any edge where io_strobe=1 and the synchronized frame
// (en_s) is high; there is no backpressure, so one word per cycle is
// always taken. Strobes while en_s=0 are dropped.
module hps_cmd_decoder #(
  parameter logic [15:0] CORE_ID = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        io_enable,
  input  logic        io_strobe,
  input  logic [15:0] io_din,
  output logic [15:0] io_dout,
  output logic [31:0] joystick_0,
  output logic [31:0] joystick_1,
  output logic [1:0]  buttons,
  output logic        forced_scandoubler,
  output logic [63:0] status,
  output logic        status_upd
);

  localparam logic [15:0] CMD_JOY0_SET   = 16'h0001;
  localparam logic [15:0] CMD_JOY1_SET   = 16'h0002;
  localparam logic [15:0] CMD_BUT_SW     = 16'h0003;
  localparam logic [15:0] CMD_STATUS_SET = 16'h001E;
  localparam logic [15:0] CMD_ID_GET     = 16'h0014;
`ifdef HPS_CMD_STATUS_READBACK_EN
  localparam logic [15:0] CMD_STATUS_GET = 16'h0029;
`endif

  logic        r_en_meta;
  logic        r_en_s;
  logic [3:0]  r_idx;
  logic [15:0] r_cmd;
  logic [47:0] r_shadow;
  logic [15:0] w_dout_nxt;

  // Two-flop synchronizer for the asynchronous frame signal
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_en_meta <= 1'b0;
      r_en_s    <= 1'b0;
    end else begin
      r_en_meta <= io_enable;
      r_en_s    <= r_en_meta;
    end
  end

  // Read word to present after the current strobe (command word uses io_din)
  always_comb begin
    w_dout_nxt = 16'h0000;
    if (r_idx == 4'd0) begin
      if (io_din == CMD_ID_GET) begin
        w_dout_nxt = CORE_ID;
      end
`ifdef HPS_CMD_STATUS_READBACK_EN
      else if (io_din == CMD_STATUS_GET) begin
        w_dout_nxt = status[15:0];
      end
`endif
    end
`ifdef HPS_CMD_STATUS_READBACK_EN
    else if (r_cmd == CMD_STATUS_GET) begin
      case (r_idx)
        4'd1:    w_dout_nxt = status[31:16];
        4'd2:    w_dout_nxt = status[47:32];
        4'd3:    w_dout_nxt = status[63:48];
        default: w_dout_nxt = 16'h0000;
      endcase
    end
`endif
  end

  // Word index, command latch, shadow staging and committed outputs
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_idx              <= 4'd0;
      r_cmd              <= 16'h0000;
      r_shadow           <= 48'h0;
      io_dout            <= 16'h0000;
      joystick_0         <= 32'h0;
      joystick_1         <= 32'h0;
      buttons            <= 2'b00;
      forced_scandoubler <= 1'b0;
      status             <= 64'h0;
      status_upd         <= 1'b0;
    end else begin
      status_upd <= 1'b0;
      if (!r_en_s) begin
        // Outside a frame: partial writes are discarded here
        r_idx    <= 4'd0;
        r_cmd    <= 16'h0000;
        r_shadow <= 48'h0;
        io_dout  <= 16'h0000;
      end else if (io_strobe) begin
        io_dout <= w_dout_nxt;
        if (r_idx != 4'hF) begin
          r_idx <= r_idx + 4'd1;
        end
        if (r_idx == 4'd0) begin
          r_cmd <= io_din;
        end else begin
          case (r_cmd)
            CMD_JOY0_SET: begin
              if (r_idx == 4'd1) r_shadow[15:0] <= io_din;
              else if (r_idx == 4'd2) joystick_0 <= {io_din, r_shadow[15:0]};
            end
            CMD_JOY1_SET: begin
              if (r_idx == 4'd1) r_shadow[15:0] <= io_din;
              else if (r_idx == 4'd2) joystick_1 <= {io_din, r_shadow[15:0]};
            end
            CMD_BUT_SW: begin
              if (r_idx == 4'd1) begin
                buttons            <= io_din[1:0];
                forced_scandoubler <= io_din[4];
              end
            end
            CMD_STATUS_SET: begin
              case (r_idx)
                4'd1: r_shadow[15:0]  <= io_din;
                4'd2: r_shadow[31:16] <= io_din;
                4'd3: r_shadow[47:32] <= io_din;
                4'd4: begin
                  status     <= {io_din, r_shadow};
                  status_upd <= 1'b1;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
